// File: rtl/hm2_gpio_pkg.sv
// Shared types and constants for the hostmot2 GPIO header mux.
package hm2_gpio_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF      = 2'd0,
        MODE_DIRECT   = 2'd1,
        MODE_DB25     = 2'd2,
        MODE_LOOPBACK = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } fsm_t;

    // Header pin driven by each hostmot2 port bit on the DE0-Nano DB25 adaptor.
    localparam int DB25_N = 17;
    localparam int DB25_MAP [DB25_N] = '{
        1, 3, 5, 7, 9, 11, 13, 15, 17, 19, 21, 23, 25, 27, 29, 31, 33
    };

endpackage

// File: rtl/hm2_led_stretch.sv
// Holds an LED on for STRETCH_CYCLES after the last activity strobe.
module hm2_led_stretch #(
    parameter int STRETCH_CYCLES = 5000000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_led,
    output logic o_led
);

    localparam int CNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_led;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else begin
            if (i_led)
                r_cnt <= RELOAD;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - ONE;
            r_led <= (r_cnt != '0) | i_led;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/hm2_gpio_port_mux.sv
// Maps hostmot2 ports onto expansion headers with per-header runtime modes,
// break-before-make mode commits, input synchronisers and LED stretchers.
//
//   state | meaning
//   IDLE  | modes stable, waiting for a commit
//   DRAIN | oe forced low on every header whose mode is about to change
//   APPLY | committed modes copied to active; pending commit restarts DRAIN
module hm2_gpio_port_mux
    import hm2_gpio_pkg::*;
#(
    parameter  int NUM_GPIO       = 2,
    parameter  int GPIO_WIDTH     = 36,
    parameter  int PORT_WIDTH     = 17,
    parameter  int SYNC_STAGES    = 2,
    parameter  int LED_COUNT      = 2,
    parameter  int STRETCH_CYCLES = 5000000,
    localparam int IO_WIDTH       = NUM_GPIO * PORT_WIDTH,
    localparam int PIN_W          = NUM_GPIO * GPIO_WIDTH,
    localparam int SEL_W          = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [IO_WIDTH-1:0]        i_io_out,
    input  logic [IO_WIDTH-1:0]        i_io_oe,
    output logic [IO_WIDTH-1:0]        o_io_in,
    input  logic [PIN_W-1:0]           i_gpio_in,
    output logic [PIN_W-1:0]           o_gpio_out,
    output logic [PIN_W-1:0]           o_gpio_oe,
    input  logic                       i_cfg_wr,
    input  logic [SEL_W-1:0]           i_cfg_sel,
    input  logic [1:0]                 i_cfg_mode,
    input  logic                       i_cfg_commit,
    output logic                       o_cfg_busy,
    output logic [2*NUM_GPIO-1:0]      o_active_mode,
    input  logic [LED_COUNT-1:0]       i_led_in,
    output logic [LED_COUNT-1:0]       o_led_out
);

    localparam int DB25_BITS = (PORT_WIDTH < DB25_N) ? PORT_WIDTH : DB25_N;
    localparam int CHAIN     = SYNC_STAGES - 1;
    localparam int MODES_W   = MODE_W * NUM_GPIO;

    fsm_t               r_state;
    logic [MODES_W-1:0] r_shadow;
    logic [MODES_W-1:0] r_target;
    logic [MODES_W-1:0] r_active;
    logic [MODES_W-1:0] w_shadow_nxt;
    logic               r_pending;
    logic               r_busy;

    logic [PIN_W-1:0]    r_pin_sync [CHAIN];
    logic [IO_WIDTH-1:0] r_lb_sync  [CHAIN];
    logic [PIN_W-1:0]    w_gpio_out, w_gpio_oe, r_gpio_out, r_gpio_oe;
    logic [IO_WIDTH-1:0] w_io_in, r_io_in;

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (i_cfg_wr && (32'(i_cfg_sel) < NUM_GPIO))
            w_shadow_nxt[32'(i_cfg_sel)*MODE_W +: MODE_W] = i_cfg_mode;
    end

    // r_target freezes the commit snapshot so writes during a sequence wait for the next commit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_shadow  <= '0;
            r_target  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_busy   <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_commit) begin
                        r_target <= w_shadow_nxt;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_cfg_commit)
                        r_pending <= 1'b1;
                    r_state <= ST_APPLY;
                end
                ST_APPLY: begin
                    r_active <= r_target;
                    if (r_pending || i_cfg_commit) begin
                        r_target  <= w_shadow_nxt;
                        r_pending <= 1'b0;
                        r_state   <= ST_DRAIN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar h = 0; h < NUM_GPIO; h++) begin : g_hdr
        mode_t                 w_mode;
        logic                  w_drain;
        logic [GPIO_WIDTH-1:0] w_pin_out, w_pin_oe, w_pin_in;
        logic [PORT_WIDTH-1:0] w_port_out, w_port_oe, w_port_in, w_port_lb;

        assign w_mode     = mode_t'(r_active[h*MODE_W +: MODE_W]);
        assign w_drain    = (r_state != ST_IDLE) &&
                            (r_target[h*MODE_W +: MODE_W] != r_active[h*MODE_W +: MODE_W]);
        assign w_port_out = i_io_out[h*PORT_WIDTH +: PORT_WIDTH];
        assign w_port_oe  = i_io_oe[h*PORT_WIDTH +: PORT_WIDTH];
        assign w_pin_in   = r_pin_sync[CHAIN-1][h*GPIO_WIDTH +: GPIO_WIDTH];
        assign w_port_lb  = r_lb_sync[CHAIN-1][h*PORT_WIDTH +: PORT_WIDTH];

        always_comb begin
            w_pin_out = '0;
            w_pin_oe  = '0;
            w_port_in = '0;
            case (w_mode)
                MODE_DIRECT: begin
                    for (int k = 0; k < PORT_WIDTH; k++) begin
                        w_pin_out[k] = w_port_out[k];
                        w_pin_oe[k]  = w_port_oe[k];
                        w_port_in[k] = w_pin_in[k];
                    end
                end
                MODE_DB25: begin
                    for (int k = 0; k < DB25_BITS; k++) begin
                        w_pin_out[DB25_MAP[k]] = w_port_out[k];
                        w_pin_oe[DB25_MAP[k]]  = w_port_oe[k];
                        w_port_in[k]           = w_pin_in[DB25_MAP[k]];
                    end
                end
                MODE_LOOPBACK: w_port_in = w_port_lb;
                default: ;
            endcase
            if (w_drain)
                w_pin_oe = '0;
        end

        assign w_gpio_out[h*GPIO_WIDTH +: GPIO_WIDTH] = w_pin_out;
        assign w_gpio_oe[h*GPIO_WIDTH +: GPIO_WIDTH]  = w_pin_oe;
        assign w_io_in[h*PORT_WIDTH +: PORT_WIDTH]    = w_port_in;
    end

    // The final io_in register is the last synchroniser stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < CHAIN; i++) begin
                r_pin_sync[i] <= '0;
                r_lb_sync[i]  <= '0;
            end
            r_gpio_out <= '0;
            r_gpio_oe  <= '0;
            r_io_in    <= '0;
        end else begin
            r_pin_sync[0] <= i_gpio_in;
            r_lb_sync[0]  <= i_io_out;
            for (int i = 1; i < CHAIN; i++) begin
                r_pin_sync[i] <= r_pin_sync[i-1];
                r_lb_sync[i]  <= r_lb_sync[i-1];
            end
            r_gpio_out <= w_gpio_out;
            r_gpio_oe  <= w_gpio_oe;
            r_io_in    <= w_io_in;
        end
    end

    for (genvar l = 0; l < LED_COUNT; l++) begin : g_led
        hm2_led_stretch #(
            .STRETCH_CYCLES(STRETCH_CYCLES)
        ) u_led (
            .i_clk    (i_clk),
            .i_reset_n(i_reset_n),
            .i_led    (i_led_in[l]),
            .o_led    (o_led_out[l])
        );
    end

    assign o_gpio_out    = r_gpio_out;
    assign o_gpio_oe     = r_gpio_oe;
    assign o_io_in       = r_io_in;
    assign o_cfg_busy    = r_busy;
    assign o_active_mode = r_active;

endmodule
